// File: rtl/decode_imm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_imm_sequencer_if
//  Brief    : Fetch-side and decode-side handshake bundle for the decode buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface decode_imm_sequencer_if #(
    parameter int PC_W = 32
);
    logic            if_valid;
    logic [31:0]     if_inst;
    logic [PC_W-1:0] if_pc;
    logic            if_ready;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [PC_W-1:0] id_pc;
    logic [2:0]      id_immType;
    logic            id_illegal;

    // Master is the environment (fetch + decode); slave is the buffer itself.
    modport master (
        output if_valid, if_inst, if_pc, id_ready,
        input  if_ready, id_valid, id_inst, id_pc, id_immType, id_illegal
    );

    modport slave (
        input  if_valid, if_inst, if_pc, id_ready,
        output if_ready, id_valid, id_inst, id_pc, id_immType, id_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_imm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : decode_imm_sequencer
//  Brief    : 2-entry fetch->decode skid FIFO with opcode to immType classify.
//             Optional macro DECODE_PERF_CNT_EN adds stall/bubble counters.
//  Revision : 1.0  initial release
// ============================================================================
module decode_imm_sequencer #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   flush,
`ifdef DECODE_PERF_CNT_EN
    output logic [31:0]           stall_cnt,
    output logic [31:0]           bubble_cnt,
`endif
    decode_imm_sequencer_if.slave bus
);

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_R = 3'b001;
    localparam logic [2:0] c_IMM_S = 3'b010;
    localparam logic [2:0] c_IMM_B = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;
    localparam logic [2:0] c_IMM_J = 3'b101;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [2:0]      imm;
        logic            ill;
    } entry_t;

    state_t r_state;
    state_t w_state_next;
    entry_t r_slot0;
    entry_t r_slot1;
    entry_t w_slot0_next;
    entry_t w_slot1_next;
    entry_t w_new;

    logic   w_if_ready;
    logic   w_id_valid;
    logic   w_accept;
    logic   w_issue;

    // Classification happens on write so the head output is a plain register.
    function automatic entry_t make_entry(input logic [31:0] inst, input logic [PC_W-1:0] pc);
        entry_t e;
        e.inst = inst;
        e.pc   = pc;
        e.ill  = 1'b0;
        e.imm  = c_IMM_R;
        case (inst[6:0])
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM: e.imm = c_IMM_I;
            c_OP_STORE:                                 e.imm = c_IMM_S;
            c_OP_BRANCH:                                e.imm = c_IMM_B;
            c_OP_LUI, c_OP_AUIPC:                       e.imm = c_IMM_U;
            c_OP_JAL:                                   e.imm = c_IMM_J;
            c_OP_REG:                                   e.imm = c_IMM_R;
            default: begin
                e.imm = c_IMM_R;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    assign w_new      = make_entry(bus.if_inst, bus.if_pc);
    assign w_if_ready = (r_state != S_FULL) & ~rst;
    assign w_id_valid = (r_state != S_EMPTY);
    assign w_accept   = bus.if_valid & w_if_ready;
    assign w_issue    = w_id_valid & bus.id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_state <= w_state_next;
            r_slot0 <= w_slot0_next;
            r_slot1 <= w_slot1_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_slot0_next = r_slot0;
        w_slot1_next = r_slot1;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_slot0_next = w_new;
                        w_state_next = S_ONE;
                    end
                end
                S_ONE: begin
                    case ({w_accept, w_issue})
                        2'b11: w_slot0_next = w_new;
                        2'b10: begin
                            w_slot1_next = w_new;
                            w_state_next = S_FULL;
                        end
                        2'b01: w_state_next = S_EMPTY;
                        default: ;
                    endcase
                end
                S_FULL: begin
                    // if_ready is low here, so only the head can move.
                    if (w_issue) begin
                        w_slot0_next = r_slot1;
                        w_state_next = S_ONE;
                    end
                end
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.if_ready   = w_if_ready;
        bus.id_valid   = w_id_valid;
        bus.id_inst    = NOP_INST;
        bus.id_pc      = '0;
        bus.id_immType = 3'b000;
        bus.id_illegal = 1'b0;
        if (w_id_valid) begin
            bus.id_inst    = r_slot0.inst;
            bus.id_pc      = r_slot0.pc;
            bus.id_immType = r_slot0.imm;
            bus.id_illegal = r_slot0.ill;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_id_valid && !bus.id_ready && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!w_id_valid && (r_bubble_cnt != 32'hFFFF_FFFF))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_imm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_imm_sequencer
//  Brief    : Directed vector table, perf-counter sequence and random traffic
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_imm_sequencer;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    logic flush;
    int   n_cmp;
    int   n_err;

    decode_imm_sequencer_if #(.PC_W(32)) bus ();

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    decode_imm_sequencer #(.PC_W(32), .NOP_INST(c_NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
`ifdef DECODE_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r, f, v;
        logic [31:0] inst, pc;
        logic        rdy;
        logic        ev;
        logic [31:0] ei, ep;
        logic [2:0]  eim;
        logic        eil, er;
    } vec_t;

    function automatic vec_t mk(input logic r, f, v, input logic [31:0] inst, pc,
                                input logic rdy, ev, input logic [31:0] ei, ep,
                                input logic [2:0] eim, input logic eil, er);
        vec_t x;
        x.r = r; x.f = f; x.v = v; x.inst = inst; x.pc = pc; x.rdy = rdy;
        x.ev = ev; x.ei = ei; x.ep = ep; x.eim = eim; x.eil = eil; x.er = er;
        return x;
    endfunction

    // Reference model: FIFO contents as plain queues.
    logic [31:0] m_inst[$];
    logic [31:0] m_pc[$];

    function automatic logic [3:0] classify(input logic [31:0] inst);
        case (inst[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return 4'b0_000;
            7'h23:                      return 4'b0_010;
            7'h63:                      return 4'b0_011;
            7'h37, 7'h17:               return 4'b0_100;
            7'h6F:                      return 4'b0_101;
            7'h33:                      return 4'b0_001;
            default:                    return 4'b1_001;
        endcase
    endfunction

    task automatic model_step();
        logic acc, iss;
        if (rst || flush) begin
            m_inst.delete();
            m_pc.delete();
        end else begin
            acc = bus.if_valid && (m_inst.size() < 2);
            iss = (m_inst.size() > 0) && bus.id_ready;
            if (iss) begin
                void'(m_inst.pop_front());
                void'(m_pc.pop_front());
            end
            if (acc) begin
                m_inst.push_back(bus.if_inst);
                m_pc.push_back(bus.if_pc);
            end
        end
    endtask

    task automatic drive(input logic r, f, v, input logic [31:0] inst, pc, input logic rdy);
        @(negedge clk);
        rst = r; flush = f;
        bus.if_valid = v; bus.if_inst = inst; bus.if_pc = pc; bus.id_ready = rdy;
        #1;
    endtask

    task automatic check(input string nm, input logic ev, input logic [31:0] ei, ep,
                         input logic [2:0] eim, input logic eil, er);
        n_cmp++;
        if (bus.id_valid !== ev || bus.id_inst !== ei || bus.id_pc !== ep ||
            bus.id_immType !== eim || bus.id_illegal !== eil || bus.if_ready !== er) begin
            n_err++;
            $display("FAIL %s: got v=%b inst=%h pc=%h imm=%b ill=%b rdy=%b, want v=%b inst=%h pc=%h imm=%b ill=%b rdy=%b",
                     nm, bus.id_valid, bus.id_inst, bus.id_pc, bus.id_immType, bus.id_illegal,
                     bus.if_ready, ev, ei, ep, eim, eil, er);
        end
    endtask

    task automatic check_model(input string nm);
        logic [3:0] c;
        logic       er;
        er = (m_inst.size() < 2) && !rst;
        if (m_inst.size() == 0) begin
            check(nm, 1'b0, c_NOP, 32'h0, 3'b000, 1'b0, er);
        end else begin
            c = classify(m_inst[0]);
            check(nm, 1'b1, m_inst[0], m_pc[0], c[2:0], c[3], er);
        end
    endtask

    vec_t       vecs[22];
    logic [6:0] ops[12];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; flush = 1'b0;
        bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0; bus.id_ready = 1'b0;

        //            r f v inst          pc          rdy ev ei            ep          eim   eil er
        vecs[0]  = mk(1,0,0,32'h0,        32'h0,      0,  0, c_NOP,        32'h0,      3'd0, 0, 0);
        vecs[1]  = mk(0,0,1,32'h00500093, 32'h100,    1,  0, c_NOP,        32'h0,      3'd0, 0, 1);
        vecs[2]  = mk(0,0,0,32'h0,        32'h0,      1,  1, 32'h00500093, 32'h100,    3'd0, 0, 1);
        vecs[3]  = mk(0,0,1,32'h00112023, 32'h104,    0,  0, c_NOP,        32'h0,      3'd0, 0, 1);
        vecs[4]  = mk(0,0,1,32'h00208463, 32'h108,    0,  1, 32'h00112023, 32'h104,    3'd2, 0, 1);
        vecs[5]  = mk(0,0,1,32'h11111111, 32'h10C,    0,  1, 32'h00112023, 32'h104,    3'd2, 0, 0);
        vecs[6]  = mk(0,0,0,32'h0,        32'h0,      1,  1, 32'h00112023, 32'h104,    3'd2, 0, 0);
        vecs[7]  = mk(0,0,0,32'h0,        32'h0,      1,  1, 32'h00208463, 32'h108,    3'd3, 0, 1);
        vecs[8]  = mk(0,0,1,32'h000012B7, 32'h200,    1,  0, c_NOP,        32'h0,      3'd0, 0, 1);
        vecs[9]  = mk(0,0,1,32'h0080006F, 32'h204,    1,  1, 32'h000012B7, 32'h200,    3'd4, 0, 1);
        vecs[10] = mk(0,0,0,32'h0,        32'h0,      1,  1, 32'h0080006F, 32'h204,    3'd5, 0, 1);
        vecs[11] = mk(0,0,1,32'h00000013, 32'h300,    0,  0, c_NOP,        32'h0,      3'd0, 0, 1);
        vecs[12] = mk(0,0,1,32'h00000033, 32'h304,    0,  1, 32'h00000013, 32'h300,    3'd0, 0, 1);
        vecs[13] = mk(0,1,1,32'h00000063, 32'h308,    1,  1, 32'h00000013, 32'h300,    3'd0, 0, 0);
        vecs[14] = mk(0,0,0,32'h0,        32'h0,      1,  0, c_NOP,        32'h0,      3'd0, 0, 1);
        vecs[15] = mk(0,0,1,32'h0000007F, 32'h400,    1,  0, c_NOP,        32'h0,      3'd0, 0, 1);
        vecs[16] = mk(0,0,1,32'h00000010, 32'h404,    1,  1, 32'h0000007F, 32'h400,    3'd1, 1, 1);
        vecs[17] = mk(0,0,0,32'h0,        32'h0,      0,  1, 32'h00000010, 32'h404,    3'd1, 1, 1);
        vecs[18] = mk(1,0,1,32'h00000013, 32'h500,    1,  1, 32'h00000010, 32'h404,    3'd1, 1, 0);
        vecs[19] = mk(0,0,1,32'h00000033, 32'h600,    1,  0, c_NOP,        32'h0,      3'd0, 0, 1);
        vecs[20] = mk(0,0,0,32'h0,        32'h0,      1,  1, 32'h00000033, 32'h600,    3'd1, 0, 1);
        vecs[21] = mk(0,0,0,32'h0,        32'h0,      1,  0, c_NOP,        32'h0,      3'd0, 0, 1);

        ops[0] = 7'h13; ops[1]  = 7'h03; ops[2]  = 7'h67; ops[3]  = 7'h73;
        ops[4] = 7'h23; ops[5]  = 7'h63; ops[6]  = 7'h37; ops[7]  = 7'h17;
        ops[8] = 7'h6F; ops[9]  = 7'h33; ops[10] = 7'h7F; ops[11] = 7'h10;

        // First reset cycle: state is unknown before the first edge.
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        model_step();

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].inst, vecs[i].pc, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep,
                  vecs[i].eim, vecs[i].eil, vecs[i].er);
            model_step();
        end

`ifdef DECODE_PERF_CNT_EN
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        model_step();
        drive(0, 0, 1, 32'h00500093, 32'h700, 0);
        model_step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'h0, 32'h0, 0);
            check_model("perf_hold");
            model_step();
        end
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        n_cmp++;
        if (stall_cnt !== 32'd3 || bubble_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL perf_cnt: got stall=%0d bubble=%0d, want stall=3 bubble=1",
                     stall_cnt, bubble_cnt);
        end
        model_step();
`endif

        // Random traffic; reset first so the model and DUT start aligned.
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        model_step();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] inst;
            inst = $urandom();
            inst[6:0] = ops[$urandom_range(0, 11)];
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 6), inst, $urandom(), ($urandom_range(0, 9) < 6));
            check_model($sformatf("rand%0d", i));
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
